// File: rtl/bram_copy_pkg.sv
// Shared definitions for the BRAM block-copy sequencer.
//   state_e     : sequencer states (IDLE, READ, DRAIN, FIN)
//   WE_ALL      : full-word byte-write enable for the destination BRAM
//   WORD_STRIDE : byte distance between consecutive 32-bit words
package bram_copy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    localparam logic [3:0] WE_ALL      = 4'b1111;
    localparam int         WORD_STRIDE = 4;

endpackage

// File: rtl/bram_copy_addr_gen.sv
// Loadable word-address generator.
// Loads a byte base address with bits [1:0] forced to zero, then steps by one
// 32-bit word each cycle that adv is high. The sum wraps modulo 2^ADDR_W.
// Ports:
//   clk, rst : clock, synchronous active-high reset (address returns to 0)
//   load     : capture base (has priority over adv)
//   base     : byte base address; low two bits are dropped
//   adv      : advance by WORD_STRIDE bytes
//   addr     : current byte address
module bram_addr_gen
    import bram_copy_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = base & ~ADDR_W'(3);
        end else if (adv) begin
            // Natural overflow of the ADDR_W-bit sum gives the modulo wrap.
            addr_d = addr_q + ADDR_W'(WORD_STRIDE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/bram_copy_ctrl.sv
// Block-copy sequencer between a source BRAM read port and a destination BRAM
// write port, one 32-bit word per cycle.
// Ports:
//   BRAM_CLK, BRAM_RST      : clock, synchronous active-high reset
//   START                   : one-cycle request, only looked at in IDLE
//   SRC_BASE, DST_BASE, LEN : copy parameters, latched when START is accepted
//   BUSY, DONE              : busy window (through DONE) and completion pulse
//   SRC_ADDR, SRC_EN        : source read port; SRC_RDDATA returns a cycle later
//   DST_ADDR, DST_WRDATA,
//   DST_EN, DST_WE          : destination write port
//   DST_DONE                : destination dump trigger, pulses with DONE
//   DBG_STATE               : current sequencer state
//
// Request protocol: START is a request with no ready; it is accepted exactly
// when the sequencer is in IDLE (BUSY low) and dropped otherwise. BUSY rises
// the cycle after acceptance and falls the cycle after DONE.
module bram_copy_ctrl
    import bram_copy_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int LEN_W  = ADDR_W - 1
) (
    input  logic              BRAM_CLK,
    input  logic              BRAM_RST,
    input  logic              START,
    input  logic [ADDR_W-1:0] SRC_BASE,
    input  logic [ADDR_W-1:0] DST_BASE,
    input  logic [LEN_W-1:0]  LEN,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] SRC_ADDR,
    output logic              SRC_EN,
    input  logic [31:0]       SRC_RDDATA,
    output logic [ADDR_W-1:0] DST_ADDR,
    output logic [31:0]       DST_WRDATA,
    output logic              DST_EN,
    output logic [3:0]        DST_WE,
    output logic              DST_DONE,
    output logic [1:0]        DBG_STATE
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  remain_q, remain_d;   // reads still to issue
    logic              rd_vld_q, rd_vld_d;   // SRC_EN delayed by the BRAM read latency
    logic              accept;
    logic              reading;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;

    assign accept  = (state_q == ST_IDLE) && START;
    assign reading = (state_q == ST_READ);

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        rd_vld_d = reading;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (LEN == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d  = ST_READ;
                        remain_d = LEN;
                    end
                end
            end
            ST_READ: begin
                remain_d = remain_q - LEN_W'(1);
                if (remain_q == LEN_W'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            // The final read's data is being written this cycle.
            ST_DRAIN: state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge BRAM_CLK) begin
        if (BRAM_RST) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    // Both generators load on acceptance; the write side trails the read side
    // by one cycle because it is advanced by the delayed read-issue bit.
    bram_addr_gen #(.ADDR_W(ADDR_W)) u_src_gen (
        .clk  (BRAM_CLK),
        .rst  (BRAM_RST),
        .load (accept),
        .base (SRC_BASE),
        .adv  (reading),
        .addr (src_addr)
    );

    bram_addr_gen #(.ADDR_W(ADDR_W)) u_dst_gen (
        .clk  (BRAM_CLK),
        .rst  (BRAM_RST),
        .load (accept),
        .base (DST_BASE),
        .adv  (rd_vld_q),
        .addr (dst_addr)
    );

    // Addresses and data are masked so every BRAM output is zero when idle.
    assign SRC_EN     = reading;
    assign SRC_ADDR   = reading ? src_addr : '0;
    assign DST_EN     = rd_vld_q;
    assign DST_WE     = rd_vld_q ? WE_ALL : 4'b0000;
    assign DST_ADDR   = rd_vld_q ? dst_addr : '0;
    assign DST_WRDATA = rd_vld_q ? SRC_RDDATA : 32'd0;
    assign DONE       = (state_q == ST_FIN);
    assign DST_DONE   = (state_q == ST_FIN);
    assign BUSY       = (state_q != ST_IDLE);
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_bram_copy_ctrl.sv
module tb_bram_copy_ctrl;
  localparam int ADDR_W = 15;
  localparam int LEN_W  = 14;
  localparam int WORDS  = 8192;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_base = '0;
  logic [ADDR_W-1:0] dst_base = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy, done, src_en, dst_en, dst_done;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [31:0]       src_rddata = '0;
  logic [31:0]       dst_wrdata;
  logic [3:0]        dst_we;
  logic [1:0]        dbg_state;

  int errors = 0;
  int checks = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  bram_copy_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .BRAM_CLK(clk), .BRAM_RST(rst), .START(start),
    .SRC_BASE(src_base), .DST_BASE(dst_base), .LEN(len),
    .BUSY(busy), .DONE(done),
    .SRC_ADDR(src_addr), .SRC_EN(src_en), .SRC_RDDATA(src_rddata),
    .DST_ADDR(dst_addr), .DST_WRDATA(dst_wrdata), .DST_EN(dst_en),
    .DST_WE(dst_we), .DST_DONE(dst_done), .DBG_STATE(dbg_state)
  );

  // ---------------- BRAM models ----------------
  logic [31:0] src_mem [WORDS];
  logic [31:0] dst_mem [WORDS];
  int dump_count = 0;

  always @(posedge clk) begin
    if (src_en) src_rddata <= src_mem[src_addr[ADDR_W-1:2]];
    if (dst_en && dst_we == 4'b1111) dst_mem[dst_addr[ADDR_W-1:2]] <= dst_wrdata;
    if (dst_done) dump_count++;
  end

  // ---------------- observation of one run ----------------
  logic [ADDR_W-1:0] obs_src_q[$];
  logic [ADDR_W-1:0] obs_waddr_q[$];
  logic [31:0]       obs_wdata_q[$];
  logic              busy_q[$];
  int done_cycle, n_done, bram_act, leak;
  logic rst_snap;  // OR of all outputs at the first cycle after reset

  // ---------------- scoreboard (reference model) ----------------
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       exp_q[$];

  task automatic model_copy(input int s, input int d, input int n);
    exp_addr_q.delete();
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      int ws, wd;
      ws = (s / 4 + k) % WORDS;
      wd = (d / 4 + k) % WORDS;
      exp_addr_q.push_back(ADDR_W'(wd * 4));
      exp_q.push_back(src_mem[ws]);
    end
  endtask

  task automatic fill_src_index();
    for (int i = 0; i < WORDS; i++) src_mem[i] = i;
  endtask

  // ---------------- driver ----------------
  // START is sampled at edge 0; cycle c is observed at the negedge after edge c-1.
  // restart_cyc: cycle during which a second START is driven (0 = none).
  // rst_cyc: first cycle whose outputs must reflect a reset (0 = none).
  task automatic run_copy(input int s, input int d, input int n,
                          input int restart_cyc, input int rst_cyc);
    obs_src_q.delete(); obs_waddr_q.delete(); obs_wdata_q.delete(); busy_q.delete();
    done_cycle = -1; n_done = 0; bram_act = 0; leak = 0; rst_snap = 1'b0;
    @(negedge clk);
    src_base = ADDR_W'(s); dst_base = ADDR_W'(d); len = LEN_W'(n); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= n + 8; c++) begin
      @(negedge clk);
      if (src_en) obs_src_q.push_back(src_addr);
      if (dst_en) begin
        obs_waddr_q.push_back(dst_addr);
        obs_wdata_q.push_back(dst_wrdata);
      end
      busy_q.push_back(busy);
      if (done) begin
        n_done++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (src_en || dst_en || dst_we != 0) bram_act++;
      if (dst_we == 0 && dst_wrdata != 0) leak++;
      if (c == rst_cyc)
        rst_snap = busy | done | src_en | dst_en | dst_done | (|dst_we) |
                   (|src_addr) | (|dst_addr) | (|dst_wrdata);
      rst = (c == rst_cyc - 1);
      start = (c == restart_cyc);
      if (c == restart_cyc) begin
        len = LEN_W'(3);
        src_base = ADDR_W'(16'h0100);
      end
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, dst_done} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: busy/done/dst_done=%b want 000", {busy, done, dst_done});
    end
    checks++;
    if ({src_en, src_addr} !== '0) begin
      errors++; $display("FAIL reset_src: src_en=%b src_addr=%h want 0", src_en, src_addr);
    end
    checks++;
    if ({dst_en, dst_we, dst_addr, dst_wrdata} !== '0) begin
      errors++; $display("FAIL reset_dst: en=%b we=%b addr=%h data=%h want 0", dst_en, dst_we, dst_addr, dst_wrdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int dumps0, bad;
    fill_src_index();
    dumps0 = dump_count;
    model_copy(0, 0, 32);
    run_copy(0, 0, 32, 0, 0);
    checks++;
    if (done_cycle != 34 || n_done != 1) begin
      errors++; $display("FAIL basic_done: cycle=%0d count=%0d want cycle=34 count=1", done_cycle, n_done);
    end
    checks++;
    if (obs_wdata_q.size() != 32) begin
      errors++; $display("FAIL basic_nwr: got %0d writes want 32", obs_wdata_q.size());
    end
    for (int k = 0; k < 32 && k < obs_wdata_q.size(); k++) begin
      checks++;
      if (obs_waddr_q[k] !== exp_addr_q[k] || obs_wdata_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL basic_wr%0d: addr=%h data=%h want addr=%h data=%h",
                           k, obs_waddr_q[k], obs_wdata_q[k], exp_addr_q[k], exp_q[k]);
      end
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (dst_mem[i] !== 32'(i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL basic_mem: %0d wrong words want 0", bad);
    end
    checks++;
    if (dump_count - dumps0 != 1) begin
      errors++; $display("FAIL basic_dump: %0d dumps want 1", dump_count - dumps0);
    end
    bad = 0;
    for (int c = 1; c <= busy_q.size(); c++) if (busy_q[c-1] !== (c <= 34)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL basic_busy: %0d wrong cycles want 0", bad);
    end
  endtask

  task automatic test_zero_len();
    int bad;
    run_copy(0, 0, 0, 0, 0);
    checks++;
    if (done_cycle != 1 || n_done != 1) begin
      errors++; $display("FAIL zero_done: cycle=%0d count=%0d want cycle=1 count=1", done_cycle, n_done);
    end
    checks++;
    if (bram_act != 0) begin
      errors++; $display("FAIL zero_bram: %0d active cycles want 0", bram_act);
    end
    bad = 0;
    for (int c = 1; c <= busy_q.size(); c++) if (busy_q[c-1] !== (c == 1)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL zero_busy: %0d wrong cycles want 0", bad);
    end
  endtask

  task automatic test_busy_reject();
    int bad;
    fill_src_index();
    model_copy(32'h40, 32'h200, 16);
    run_copy(32'h40, 32'h200, 16, 5, 0);
    checks++;
    if (n_done != 1 || done_cycle != 18) begin
      errors++; $display("FAIL busy_done: count=%0d cycle=%0d want count=1 cycle=18", n_done, done_cycle);
    end
    checks++;
    if (obs_wdata_q.size() != 16) begin
      errors++; $display("FAIL busy_nwr: got %0d writes want 16", obs_wdata_q.size());
    end
    bad = 0;
    for (int k = 0; k < 16 && k < obs_wdata_q.size(); k++)
      if (obs_waddr_q[k] !== exp_addr_q[k] || obs_wdata_q[k] !== exp_q[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL busy_data: %0d wrong writes want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int dumps0;
    fill_src_index();
    for (int i = 0; i < WORDS; i++) dst_mem[i] = 32'hDEAD_BEEF;
    dumps0 = dump_count;
    run_copy(0, 0, 32, 0, 10);
    checks++;
    if (rst_snap !== 1'b0) begin
      errors++; $display("FAIL rst_outputs: some output=%b after reset want 0", rst_snap);
    end
    checks++;
    if (n_done != 0 || dump_count != dumps0) begin
      errors++; $display("FAIL rst_done: done=%0d dumps=%0d want 0 0", n_done, dump_count - dumps0);
    end
    checks++;
    if (dst_mem[7] !== 32'd7 || dst_mem[8] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rst_mem: w7=%h w8=%h want 7 deadbeef", dst_mem[7], dst_mem[8]);
    end
  endtask

  task automatic test_wrap();
    fill_src_index();
    run_copy(32'h7FF8, 32'h7FFC, 2, 0, 0);
    checks++;
    if (obs_src_q.size() != 2 || obs_src_q[0] !== 15'h7FF8 || obs_src_q[1] !== 15'h7FFC) begin
      errors++; $display("FAIL wrap_src: n=%0d a0=%h a1=%h want 7ff8 7ffc",
                         obs_src_q.size(), obs_src_q[0], obs_src_q[1]);
    end
    checks++;
    if (obs_waddr_q.size() != 2 || obs_waddr_q[0] !== 15'h7FFC || obs_waddr_q[1] !== 15'h0000) begin
      errors++; $display("FAIL wrap_dst: n=%0d a0=%h a1=%h want 7ffc 0000",
                         obs_waddr_q.size(), obs_waddr_q[0], obs_waddr_q[1]);
    end
    checks++;
    if (dst_mem[8191] !== 32'd8190 || dst_mem[0] !== 32'd8191) begin
      errors++; $display("FAIL wrap_mem: w8191=%0d w0=%0d want 8190 8191", dst_mem[8191], dst_mem[0]);
    end
  endtask

  task automatic test_unaligned();
    fill_src_index();
    run_copy(32'h0006, 32'h0103, 1, 0, 0);
    checks++;
    if (obs_src_q.size() != 1 || obs_src_q[0] !== 15'h0004) begin
      errors++; $display("FAIL unal_src: n=%0d addr=%h want 0004", obs_src_q.size(), obs_src_q[0]);
    end
    checks++;
    if (obs_waddr_q.size() != 1 || obs_waddr_q[0] !== 15'h0100 || dst_mem[64] !== 32'd1) begin
      errors++; $display("FAIL unal_dst: addr=%h mem=%h want 0100 1", obs_waddr_q[0], dst_mem[64]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int s, d, n, bad;
      s = $urandom_range(0, 32767);
      d = $urandom_range(0, 32767);
      n = $urandom_range(1, 40);
      for (int i = 0; i < WORDS; i++) src_mem[i] = $urandom;
      model_copy(s, d, n);
      run_copy(s, d, n, 0, 0);
      checks++;
      if (done_cycle != n + 2 || n_done != 1) begin
        errors++; $display("FAIL rnd%0d_done: cycle=%0d count=%0d want cycle=%0d count=1",
                           it, done_cycle, n_done, n + 2);
      end
      bad = 0;
      if (obs_wdata_q.size() != n) bad++;
      for (int k = 0; k < n && k < obs_wdata_q.size(); k++) begin
        if (obs_waddr_q[k] !== exp_addr_q[k] || obs_wdata_q[k] !== exp_q[k]) bad++;
        if (dst_mem[exp_addr_q[k][ADDR_W-1:2]] !== exp_q[k]) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL rnd%0d_data: %0d mismatching items (len=%0d) want 0", it, bad, n);
      end
      checks++;
      if (leak != 0) begin
        errors++; $display("FAIL rnd%0d_leak: wrdata nonzero with we=0 in %0d cycles want 0", it, leak);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < WORDS; i++) dst_mem[i] = '0;
    fill_src_index();
    test_reset();
    test_basic();
    test_zero_len();
    test_busy_reject();
    test_reset_mid();
    test_wrap();
    test_unaligned();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_copy_ctrl.md
# bram_copy_ctrl

Sequencer that drives a source `my_bram` read port and a destination `my_bram` write port to copy a block of 32-bit words, one word per cycle. It replaces hand-driven address/enable sequencing: it issues source reads, aligns for the one-cycle BRAM read latency, writes the returned data to the destination, then pulses the destination's `done` so the destination dumps its contents.

## Interface
Parameters:
- `ADDR_W`, default 15: byte-address width, matching `my_bram`.
- `LEN_W`, default `ADDR_W-1`: word-count width. Maximum is 2^(ADDR_W-2) words.

Ports:
- `BRAM_CLK`, in, 1: single clock for this block and both BRAMs.
- `BRAM_RST`, in, 1: reset, **synchronous, active-high**.
- `START`, in, 1: one-cycle request. Sampled only in IDLE.
- `SRC_BASE`, in, ADDR_W: source byte address. Bits [1:0] are ignored.
- `DST_BASE`, in, ADDR_W: destination byte address. Bits [1:0] are ignored.
- `LEN`, in, LEN_W: number of words to copy.
- `BUSY`, out, 1: high from the cycle after an accepted START until the cycle DONE is high (inclusive).
- `DONE`, out, 1: one-cycle completion pulse.
- `SRC_ADDR`, out, ADDR_W: source BRAM_ADDR.
- `SRC_EN`, out, 1: source BRAM_EN.
- `SRC_RDDATA`, in, 32: source BRAM_RDDATA. Registered; valid one cycle after SRC_EN.
- `DST_ADDR`, out, ADDR_W: destination BRAM_ADDR.
- `DST_WRDATA`, out, 32: destination BRAM_WRDATA.
- `DST_EN`, out, 1: destination BRAM_EN.
- `DST_WE`, out, 4: destination BRAM_WE. Either 4'b1111 or 0.
- `DST_DONE`, out, 1: drives the destination's `done`. Pulses together with DONE.

## Operation
- States:
  - IDLE: all BRAM outputs low.
  - READ: issue reads.
  - DRAIN: the final write is in flight.
  - FIN: single cycle; DONE and DST_DONE are high.
- Transitions:
  - IDLE→READ on START with LEN≠0. Latch bases with [1:0] forced to 0, and latch LEN.
  - IDLE→FIN on START with LEN=0. No BRAM access occurs.
  - READ→DRAIN after issuing the last read.
  - DRAIN→FIN after one cycle.
  - FIN→IDLE after one cycle.
- READ state: SRC_EN=1; SRC_ADDR = src_base + 4·k for k = 0..LEN-1.
- Write path: one cycle after each read issue, DST_EN=1, DST_WE=4'b1111, DST_ADDR = dst_base + 4·k, DST_WRDATA = SRC_RDDATA (combinational pass-through of the already-registered read data).
- Address arithmetic is modulo 2^ADDR_W: 0x7FFC + 4 → 0x0000. There is no error on wrap.
- START while BUSY is ignored. The latched parameters do not change mid-copy.
- BRAM_RST in any state forces IDLE and clears every output and counter. No DONE or DST_DONE pulse follows an aborted copy. Writes already performed remain in the destination.
- Overlapping source/destination regions in the same BRAM are not supported. Both regions are distinct instances.

## Timing
- Reset values: BUSY, DONE, SRC_EN, DST_EN, DST_DONE = 0; DST_WE = 0; SRC_ADDR, DST_ADDR, DST_WRDATA = 0. DST_WRDATA is 0 whenever DST_WE is 0.
- START accepted at edge 0:
  - First read is issued at cycle 1.
  - Write k occurs at cycle k+2.
  - Last write is at cycle LEN+1.
  - DONE and DST_DONE are high at cycle LEN+2.
  - Total latency is LEN+2 cycles; throughput is 1 word per cycle.
- LEN=0: DONE is high at cycle 1 and BUSY is high only at cycle 1.
- A new START is accepted in the cycle after DONE (IDLE).

## Structure
- Package `bram_copy_pkg` holds:
  - the state enum (IDLE, READ, DRAIN, FIN);
  - `WE_ALL = 4'b1111`;
  - `WORD_STRIDE = 4`.
- Sub-module `bram_addr_gen`, instantiated twice (source and destination): loadable base plus word-stride incrementer with modulo wrap.
- The write-side generator is advanced by a one-cycle-delayed copy of SRC_EN. That same delayed bit drives DST_EN and DST_WE.

## Test plan
Each bench pairs the block with two `my_bram` instances (ADDR_W=15); the source is preloaded with word i = i.

- **Basic copy:** SRC_BASE=0, DST_BASE=0, LEN=32. Destination words 0..31 equal 0..31. DONE is high exactly at cycle 34. The DST_DONE pulse triggers the output-file dump.
- **Zero length:** LEN=0. DONE is high at cycle 1. SRC_EN, DST_EN and DST_WE stay 0 throughout.
- **Busy rejection:** START again at cycle 5 of a LEN=16 copy. The second START is ignored, only one DONE occurs, and exactly 16 writes are counted.
- **Reset mid-copy:** BRAM_RST at cycle 10 of a LEN=32 copy. All outputs are 0 on the next cycle and no DONE occurs. Destination words 0..7 are written; word 8 is not.
- **Wrap:** SRC_BASE=0x7FF8, DST_BASE=0x7FFC, LEN=2. SRC_ADDR sequence is 0x7FF8, 0x7FFC. DST_ADDR sequence is 0x7FFC, 0x0000.
- **Unaligned base:** SRC_BASE=0x0006, LEN=1. SRC_ADDR is 0x0004 and the destination receives word 1.
